onehot_decoder_seq: RTL and testbench
=====================================

// Module: onehot_decoder_seq
// PURPOSE
//  Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with valid/ready input handshake.
//  Three output modes: LEVEL (hold), PULSE (fixed-length strobe) and SCAN (auto-walk, optional).
//  Drives row/LED/chip-select lines from a control FSM; next generation of the team's 4-to-16 decoder.
// PARAMETERS
//  SEL_W      4  select width; OUT_W = 1<<SEL_W (localparam)
//  PULSE_LEN  3  cycles a PULSE-mode output stays active; legal range >=1
//  SCAN_DIV   8  cycles each SCAN-mode position is held; legal range >=1
//  ACTIVE_LOW 0  1: all out bits inverted at the output register (inactive=1)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  in_valid  in   1      request valid
//  in_ready  out  1      block can accept; transfer = in_valid & in_ready
//  in_sel    in   SEL_W  index to activate / scan start index
//  in_en     in   1      0: request blanks all outputs
//  in_mode   in   2      00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved
//  out       out  OUT_W  registered one-hot (or all-inactive) vector
//  out_valid out  1      high while out carries an active index
//  mode_err  out  1      one-cycle pulse: accepted request had in_mode=11 (or 10 without DEC_SCAN_EN)
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; out=all inactive (0s, or 1s if ACTIVE_LOW); out_valid=0; in_ready=1;
//   mode_err=0; counters 0. rst mid-PULSE/SCAN aborts immediately, same values next cycle.
//  Latency: transfer at edge N -> out/out_valid updated at edge N+1 (visible from cycle N+1). All mode
//   behaviour uses the mode captured at transfer.
//  FSM states IDLE, HOLD, PULSE, SCAN:
//   any state except PULSE, transfer with in_en=0 -> IDLE, out inactive, out_valid=0 (any mode).
//   transfer LEVEL, in_en=1 -> HOLD; out=1<<in_sel held until the next transfer.
//   transfer PULSE, in_en=1 -> PULSE; out=1<<in_sel for exactly PULSE_LEN cycles, then IDLE with out inactive.
//    in_ready=0 throughout PULSE; it is 1 again in the first IDLE cycle (no back-to-back overlap).
//   transfer SCAN, in_en=1 -> SCAN; out starts at in_sel, advances by +1 every SCAN_DIV cycles,
//    wraps OUT_W-1 -> 0; runs until the next transfer. in_ready=1 in SCAN.
//   in_mode=11 -> treated as LEVEL; mode_err=1 for the cycle out updates.
//  in_ready: 1 in IDLE/HOLD/SCAN, 0 in PULSE. Inputs ignored when not ready.
//  Index arithmetic modulo OUT_W; counters sized $clog2(max(PULSE_LEN,SCAN_DIV))+1.
//  out is never multi-hot; exactly one bit is active while out_valid=1, none while out_valid=0.
// CONFIGURATION
//  DEC_SCAN_EN defined: SCAN mode, scan index register and divider compiled in.
//  DEC_SCAN_EN undefined: no SCAN state/logic; in_mode=10 behaves as 11 (LEVEL + mode_err pulse).
// STRUCTURE
//  Package decoder_pkg: mode encodings (MODE_LEVEL/PULSE/SCAN/RSVD), FSM state typedef.
//  Sub-module onehot_dec: pure combinational SEL_W -> OUT_W decoder with enable, instantiated once;
//   top holds FSM, counters, scan index, output register and ACTIVE_LOW inversion.
// TESTING (SEL_W=4, PULSE_LEN=3, SCAN_DIV=2, ACTIVE_LOW=0 unless stated)
//  1 Reset then LEVEL sel=5 en=1 -> next cycle out=16'h0020, out_valid=1, held 10 cycles; LEVEL en=0 -> out=0.
//  2 PULSE sel=15 -> out=16'h8000 for exactly 3 cycles, in_ready=0 those 3 cycles, then out=0, in_ready=1.
//  3 SCAN sel=14 (DEC_SCAN_EN) -> out 0x4000,0x4000,0x8000,0x8000,0x0001,0x0001..; LEVEL sel=3 mid-scan -> 0x0008.
//  4 rst asserted 2nd cycle of PULSE -> next cycle out=0, out_valid=0, in_ready=1; in_valid during pulse ignored.
//  5 in_mode=11 sel=2 -> out=16'h0004, mode_err=1 one cycle; without DEC_SCAN_EN, mode=10 same result.
//  6 ACTIVE_LOW=1: after reset out=16'hFFFF; LEVEL sel=0 -> out=16'hFFFE.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared encodings for the registered one-hot decoder: request modes, FSM states
// and the counter-width helper.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_PULSE = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_PULSE = 2'b10
`ifdef DEC_SCAN_EN
    , ST_SCAN = 2'b11
`endif
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit so a terminal count of exactly 2^n still fits.
  function automatic int cnt_width(input int pulse_len, input int scan_div);
    return $clog2(max_int(pulse_len, scan_div)) + 1;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Pure combinational SEL_W -> 2^SEL_W one-hot decoder; all-zero when en is low.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [(1<<SEL_W)-1:0] onehot
);

  // Single active bit at position sel, or nothing when disabled.
  always_comb begin
    onehot = {(1<<SEL_W){1'b0}};
    if (en) begin
      onehot[sel] = 1'b1;
    end else begin
      onehot = {(1<<SEL_W){1'b0}};
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with valid/ready input and LEVEL/PULSE/SCAN output modes.
// SCAN mode is only built when the DEC_SCAN_EN macro is defined.
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 4,
  parameter int PULSE_LEN  = 3,
  parameter int SCAN_DIV   = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_en,
  input  logic [1:0]            in_mode,
  output logic [(1<<SEL_W)-1:0] out,
  output logic                  out_valid,
  output logic                  mode_err
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = cnt_width(PULSE_LEN, SCAN_DIV);
  // XOR mask applied at the output register; equals the inactive pattern.
  localparam logic [OUT_W-1:0] OUT_INACT  = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
`ifdef DEC_SCAN_EN
  localparam logic [CNT_W-1:0] SCAN_LOAD  = CNT_W'(SCAN_DIV - 1);
`endif

  state_e           state_r;
  logic [OUT_W-1:0] out_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             mode_err_r;
  logic [CNT_W-1:0] cnt_r;
`ifdef DEC_SCAN_EN
  logic [SEL_W-1:0] idx_r;
`endif

  logic             accept_s;
  mode_e            mode_s;
  mode_e            eff_mode_s;
  logic             mode_bad_s;
  logic [SEL_W-1:0] dec_sel_s;
  logic             dec_en_s;
  logic [OUT_W-1:0] dec_out_s;

  assign accept_s = in_valid & in_ready_r;

  // Map the requested mode to the one actually executed; unsupported modes fall back to LEVEL.
  always_comb begin
    mode_s     = mode_e'(in_mode);
    eff_mode_s = MODE_LEVEL;
    mode_bad_s = 1'b0;
    case (mode_s)
      MODE_LEVEL: begin
        eff_mode_s = MODE_LEVEL;
        mode_bad_s = 1'b0;
      end
      MODE_PULSE: begin
        eff_mode_s = MODE_PULSE;
        mode_bad_s = 1'b0;
      end
`ifdef DEC_SCAN_EN
      MODE_SCAN: begin
        eff_mode_s = MODE_SCAN;
        mode_bad_s = 1'b0;
      end
`else
      MODE_SCAN: begin
        eff_mode_s = MODE_LEVEL;
        mode_bad_s = 1'b1;
      end
`endif
      MODE_RSVD: begin
        eff_mode_s = MODE_LEVEL;
        mode_bad_s = 1'b1;
      end
      default: begin
        eff_mode_s = MODE_LEVEL;
        mode_bad_s = 1'b1;
      end
    endcase
  end

  // Shared decoder input: a new request's index, otherwise the next scan position.
  always_comb begin
    dec_sel_s = in_sel;
    dec_en_s  = in_en;
`ifdef DEC_SCAN_EN
    if (accept_s) begin
      dec_sel_s = in_sel;
      dec_en_s  = in_en;
    end else begin
      dec_sel_s = idx_r + SEL_W'(1);
      dec_en_s  = 1'b1;
    end
`endif
  end

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel    (dec_sel_s),
    .en     (dec_en_s),
    .onehot (dec_out_s)
  );

  // Control FSM, pulse/scan counters and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      out_r       <= OUT_INACT;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      mode_err_r  <= 1'b0;
      cnt_r       <= CNT_ZERO;
`ifdef DEC_SCAN_EN
      idx_r       <= {SEL_W{1'b0}};
`endif
    end else if (accept_s) begin
      mode_err_r <= mode_bad_s;
      cnt_r      <= CNT_ZERO;
      if (!in_en) begin
        state_r     <= ST_IDLE;
        out_r       <= OUT_INACT;
        out_valid_r <= 1'b0;
        in_ready_r  <= 1'b1;
      end else begin
        out_r       <= dec_out_s ^ OUT_INACT;
        out_valid_r <= 1'b1;
        case (eff_mode_s)
          MODE_PULSE: begin
            state_r    <= ST_PULSE;
            cnt_r      <= PULSE_LOAD;
            in_ready_r <= 1'b0;
          end
`ifdef DEC_SCAN_EN
          MODE_SCAN: begin
            state_r    <= ST_SCAN;
            cnt_r      <= SCAN_LOAD;
            idx_r      <= in_sel;
            in_ready_r <= 1'b1;
          end
`endif
          default: begin
            state_r    <= ST_HOLD;
            in_ready_r <= 1'b1;
          end
        endcase
      end
    end else begin
      mode_err_r <= 1'b0;
      case (state_r)
        ST_PULSE: begin
          if (cnt_r == CNT_ZERO) begin
            state_r     <= ST_IDLE;
            out_r       <= OUT_INACT;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
`ifdef DEC_SCAN_EN
        ST_SCAN: begin
          if (cnt_r == CNT_ZERO) begin
            idx_r <= dec_sel_s;
            out_r <= dec_out_s ^ OUT_INACT;
            cnt_r <= SCAN_LOAD;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
`endif
        default: begin
          state_r <= state_r;
        end
      endcase
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;
  assign mode_err  = mode_err_r;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_onehot_decoder_seq;

  localparam int SEL_W     = 4;
  localparam int PULSE_LEN = 3;
  localparam int SCAN_DIV  = 2;
  localparam int OUT_W     = 16;
`ifdef DEC_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_en;
  logic [3:0]  in_sel;
  logic [1:0]  in_mode;
  logic        in_ready, out_valid, mode_err;
  logic [15:0] out;
  logic        in_ready_al, out_valid_al, mode_err_al;
  logic [15:0] out_al;

  int errors = 0;
  int checks = 0;

  // Behavioural model: kind 0 off, 1 hold, 2 pulse, 3 scan.
  int m_kind = 0;
  int m_idx = 0;
  int m_left = 0;
  int m_phase = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.SEL_W(SEL_W), .PULSE_LEN(PULSE_LEN), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_en(in_en), .in_mode(in_mode), .out(out), .out_valid(out_valid), .mode_err(mode_err)
  );

  onehot_decoder_seq #(.SEL_W(SEL_W), .PULSE_LEN(PULSE_LEN), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_al), .in_sel(in_sel),
    .in_en(in_en), .in_mode(in_mode), .out(out_al), .out_valid(out_valid_al), .mode_err(mode_err_al)
  );

  function automatic logic [15:0] exp_out();
    logic [15:0] v;
    v = 16'h0001 << m_idx;
    return (m_kind != 0) ? v : 16'h0000;
  endfunction

  task automatic model_update();
    bit rdy;
    int md;
    rdy = (m_kind != 2);
    if (rst) begin
      m_kind = 0; m_err = 1'b0; m_left = 0; m_phase = 0;
    end else if (in_valid && rdy) begin
      md = int'(in_mode);
      m_err = (md == 3) || (md == 2 && !SCAN_EN);
      if (m_err) md = 0;
      if (!in_en) begin
        m_kind = 0;
      end else begin
        m_idx = int'(in_sel);
        m_left = PULSE_LEN;
        m_phase = 0;
        m_kind = (md == 1) ? 2 : (md == 2) ? 3 : 1;
      end
    end else begin
      m_err = 1'b0;
      if (m_kind == 2) begin
        m_left--;
        if (m_left == 0) m_kind = 0;
      end else if (m_kind == 3) begin
        m_phase++;
        if (m_phase == SCAN_DIV) begin
          m_phase = 0;
          m_idx = (m_idx + 1) % OUT_W;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_en = 1'b1; in_sel = 4'd0; in_mode = 2'b00;
    tick(); tick();
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected %h", out, 16'h0000); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", mode_err); end
    checks++; if (out_al !== 16'hFFFF) begin errors++; $display("FAIL reset_out_al: got %h expected %h", out_al, 16'hFFFF); end
    rst = 1'b0;
  endtask

  task automatic test_level();
    in_valid = 1'b1; in_mode = 2'b00; in_sel = 4'd5; in_en = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out !== 16'h0020 || out_valid !== 1'b1) begin
        errors++; $display("FAIL level_hold[%0d]: got %h/%b expected 0020/1", i, out, out_valid);
      end
      tick();
    end
    in_valid = 1'b1; in_en = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL level_blank: got %h/%b expected 0000/0", out, out_valid);
    end
  endtask

  task automatic test_pulse();
    in_valid = 1'b1; in_mode = 2'b01; in_sel = 4'd15; in_en = 1'b1;
    tick();
    in_mode = 2'b00; in_sel = 4'd3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out !== 16'h8000 || in_ready !== 1'b0) begin
        errors++; $display("FAIL pulse_active[%0d]: got %h/ready %b expected 8000/0", i, out, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out !== 16'h0000 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL pulse_end: got %h/ready %b/valid %b expected 0000/1/0", out, in_ready, out_valid);
    end
  endtask

`ifdef DEC_SCAN_EN
  task automatic test_scan();
    logic [15:0] seq [6];
    seq = '{16'h4000, 16'h4000, 16'h8000, 16'h8000, 16'h0001, 16'h0001};
    in_valid = 1'b1; in_mode = 2'b10; in_sel = 4'd14; in_en = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out !== seq[i] || in_ready !== 1'b1) begin
        errors++; $display("FAIL scan_seq[%0d]: got %h expected %h", i, out, seq[i]);
      end
      tick();
    end
    in_valid = 1'b1; in_mode = 2'b00; in_sel = 4'd3;
    tick();
    in_valid = 1'b0;
    checks++; if (out !== 16'h0008) begin errors++; $display("FAIL scan_to_level: got %h expected %h", out, 16'h0008); end
  endtask
`endif

  task automatic test_reset_mid_pulse();
    in_valid = 1'b1; in_mode = 2'b01; in_sel = 4'd9; in_en = 1'b1;
    tick();
    in_mode = 2'b00; in_sel = 4'd2;
    tick();
    checks++; if (out !== 16'h0200) begin errors++; $display("FAIL pulse_ignores_input: got %h expected %h", out, 16'h0200); end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    checks++; if (out !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL pulse_reset: got %h/valid %b/ready %b expected 0000/0/1", out, out_valid, in_ready);
    end
    rst = 1'b0;
    tick();
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL pulse_reset_after: got %h expected 0000", out); end
  endtask

  task automatic test_mode_err();
    in_valid = 1'b1; in_mode = 2'b11; in_sel = 4'd2; in_en = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out !== 16'h0004 || mode_err !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rsvd_mode: got %h/err %b expected 0004/1", out, mode_err);
    end
    tick();
    checks++; if (mode_err !== 1'b0 || out !== 16'h0004) begin
      errors++; $display("FAIL rsvd_err_pulse: got err %b/%h expected 0/0004", mode_err, out);
    end
`ifndef DEC_SCAN_EN
    in_valid = 1'b1; in_mode = 2'b10; in_sel = 4'd6;
    tick();
    in_valid = 1'b0;
    checks++; if (out !== 16'h0040 || mode_err !== 1'b1) begin
      errors++; $display("FAIL scan_disabled: got %h/err %b expected 0040/1", out, mode_err);
    end
    tick();
    checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL scan_disabled_err: got %b expected 0", mode_err); end
`endif
  endtask

  task automatic test_active_low();
    in_valid = 1'b1; in_mode = 2'b00; in_sel = 4'd0; in_en = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_al !== 16'hFFFE || out_valid_al !== 1'b1) begin
      errors++; $display("FAIL active_low: got %h/%b expected FFFE/1", out_al, out_valid_al);
    end
    checks++; if (out !== 16'h0001) begin errors++; $display("FAIL active_high_ref: got %h expected 0001", out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_mode  = 2'($urandom_range(0, 3));
      in_sel   = 4'($urandom_range(0, 15));
      in_en    = ($urandom_range(0, 5) != 0);
      tick();
      checks++;
      if (out !== exp_out() || out_valid !== (m_kind != 0) || in_ready !== (m_kind != 2) ||
          mode_err !== m_err || out_al !== ~exp_out()) begin
        errors++;
        $display("FAIL random[%0d]: got out %h v %b r %b e %b al %h expected %h %b %b %b %h", i, out, out_valid,
                 in_ready, mode_err, out_al, exp_out(), (m_kind != 0), (m_kind != 2), m_err, ~exp_out());
      end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_pulse();
`ifdef DEC_SCAN_EN
    test_scan();
`endif
    test_reset_mid_pulse();
    test_mode_err();
    test_active_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
